// File: rtl/feature_fetch_engine.sv
// Burst fetch engine: streams COUNT beats from external memory into one of NUM_BUF
// on-chip buffers, with bounded outstanding reads and a strided destination address.
module feature_fetch_engine #(
    parameter int DATA_W     = 128,
    parameter int SRC_AW     = 32,
    parameter int DST_AW     = 15,
    parameter int CNT_W      = 8,
    parameter int NUM_BUF    = 2,
    parameter int MAX_OUTST  = 4,
    parameter int SRC_OFFSET = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [SRC_AW-1:0] cmd_src,
    input  logic [DST_AW-1:0] cmd_dst,
    input  logic [DST_AW-1:0] cmd_stride,
    input  logic [CNT_W-1:0]  cmd_count,
    input  logic [7:0]        cmd_buf,
    output logic              rd_req,
    output logic [SRC_AW-1:0] rd_addr,
    input  logic              rd_gnt,
    input  logic              rd_valid,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [DST_AW-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [NUM_BUF-1:0] wr_sel,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [8:0] NUM_BUF_W = 9'(NUM_BUF);
    localparam logic [3:0] MAX_OUTST_W = 4'(MAX_OUTST);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic [SRC_AW-1:0]   r_src_base;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    r_issued;
    logic [CNT_W-1:0]    r_returned;
    logic [3:0]          r_outst;
    logic [DST_AW-1:0]   r_stride;
    logic [DST_AW-1:0]   r_dst_acc;
    logic                r_wr_en;
    logic [DST_AW-1:0]   r_wr_addr;
    logic [DATA_W-1:0]   r_wr_data;
    logic [NUM_BUF-1:0]  r_wr_sel;
    logic                r_err;

    logic                w_accept;
    logic                w_rd_req;
    logic                w_grant;
    logic                w_last_grant;
    logic                w_beat_ok;
    logic                w_beat_bad;
    logic                w_buf_bad;
    logic [NUM_BUF-1:0]  w_sel_onehot;

    // Out-of-range buffer indices decode to an all-zero select.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BUF; gi++) begin : g_sel
            assign w_sel_onehot[gi] = (cmd_buf == 8'(gi));
        end
    endgenerate

    assign w_buf_bad    = ({1'b0, cmd_buf} >= NUM_BUF_W);
    assign w_accept     = cmd_valid && (r_state == S_IDLE);
    // Only registered state feeds the request, so it stays put until granted.
    assign w_rd_req     = (r_state == S_ISSUE) && (r_issued < r_count) && (r_outst < MAX_OUTST_W);
    assign w_grant      = w_rd_req && rd_gnt;
    assign w_last_grant = w_grant && ((r_issued + CNT_W'(1)) == r_count);
    assign w_beat_ok    = rd_valid && (r_outst != 4'd0);
    assign w_beat_bad   = rd_valid && (r_outst == 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_src_base <= '0;
            r_count    <= '0;
            r_issued   <= '0;
            r_returned <= '0;
            r_outst    <= '0;
            r_stride   <= '0;
            r_dst_acc  <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_wr_sel   <= '0;
            r_err      <= 1'b0;
        end else begin
            r_wr_en <= w_beat_ok;
            if (w_beat_ok) begin
                r_wr_data  <= rd_data;
                r_wr_addr  <= r_dst_acc;
                r_dst_acc  <= r_dst_acc + r_stride;
                r_returned <= r_returned + CNT_W'(1);
            end

            case ({w_grant, w_beat_ok})
                2'b10:   r_outst <= r_outst + 4'd1;
                2'b01:   r_outst <= r_outst - 4'd1;
                default: r_outst <= r_outst;
            endcase

            if (w_grant) begin
                r_issued <= r_issued + CNT_W'(1);
            end

            if (w_beat_bad) begin
                r_err <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_src_base <= cmd_src + SRC_AW'(SRC_OFFSET);
                        r_count    <= cmd_count;
                        r_issued   <= '0;
                        r_returned <= '0;
                        r_stride   <= cmd_stride;
                        r_dst_acc  <= cmd_dst;
                        r_wr_sel   <= w_sel_onehot;
                        r_err      <= w_buf_bad || w_beat_bad;
                        r_state    <= (cmd_count == '0) ? S_DONE : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_last_grant) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // r_wr_en here is the write of the beat that completed the count.
                    if (r_wr_en && (r_returned == r_count)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign rd_req    = w_rd_req;
    assign rd_addr   = r_src_base + SRC_AW'(r_issued);
    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign wr_sel    = r_wr_sel;
    assign err       = r_err;

endmodule
